// File: rtl/ad_ip_jesd204_tpl_dac_dma_prefill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_dma_prefill_pkg
// Description : Shared constants for the DAC TPL DMA prefill buffer:
//               FSM state encodings, channel data-select code and a
//               saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ad_ip_jesd204_tpl_dac_dma_prefill_pkg;

   // FSM state encodings
   localparam logic [1:0] c_ST_IDLE      = 2'd0;
   localparam logic [1:0] c_ST_PREFILL   = 2'd1;
   localparam logic [1:0] c_ST_RUN       = 2'd2;
   localparam logic [1:0] c_ST_UNDERFLOW = 2'd3;

   // Channel data-select value that routes the DMA path to the DAC
   localparam logic [3:0] c_DATA_SEL_DMA = 4'h2;

   // 16-bit increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] f_sat_inc16(input logic [15:0] i_val);
      return (i_val == 16'hFFFF) ? i_val : (i_val + 16'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_dma_prefill_mem.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_dma_prefill_mem
// Description : Simple dual-port storage array, synchronous write and
//               asynchronous (distributed) read. The array has no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_dma_prefill_mem #(
   parameter int WIDTH  = 64,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

   // Write port: store a beat at the write pointer
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_dma_prefill.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_dma_prefill
// Description : Elastic buffer in front of the DAC TPL channel DMA input.
//               Accepts bursty valid/ready beats, prefills to a threshold
//               once the channel selects DMA, then emits one beat per clock.
//               Empty-while-running is flagged, counted and replaced by
//               zeros, after which the buffer refills before resuming.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_dma_prefill
   import ad_ip_jesd204_tpl_dac_dma_prefill_pkg::*;
#(
   parameter int DATA_PATH_WIDTH = 4,
   parameter int BITS_PER_SAMPLE = 16,
   parameter int DEPTH_LOG2      = 4,
   parameter int PREFILL_LEVEL   = 8
) (
   input  logic                                       clk,
   input  logic                                       resetn,
   input  logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] s_axis_data,
   input  logic                                       s_axis_valid,
   output logic                                       s_axis_ready,
   input  logic                                       dac_enable,
   input  logic                                       dac_data_sync,
   output logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0] dma_data,
   output logic                                       dma_underflow,
   output logic [15:0]                                underflow_cnt,
   output logic [DEPTH_LOG2:0]                        fifo_level
);

   localparam int                  c_W         = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
   localparam logic [DEPTH_LOG2:0] c_LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] c_LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] c_LVL_PRE   = PREFILL_LEVEL[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic [DEPTH_LOG2:0]   w_level_nxt;
   logic                  r_ready;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_uf;
   logic [c_W-1:0]        w_rd_data;
   logic [c_W-1:0]        r_dma_data;
   logic                  r_dma_underflow;
   logic [15:0]           r_underflow_cnt;

   // Sync drops the handshake in the same cycle so no beat appears accepted during a flush
   assign s_axis_ready  = r_ready & ~dac_data_sync;
   assign w_push        = s_axis_valid & s_axis_ready;
   assign dma_data      = r_dma_data;
   assign dma_underflow = r_dma_underflow;
   assign underflow_cnt = r_underflow_cnt;
   assign fifo_level    = r_level;

   ad_ip_jesd204_tpl_dac_dma_prefill_mem #(
      .WIDTH  (c_W),
      .ADDR_W (DEPTH_LOG2)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (s_axis_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state decode; sync overrides every other transition
   always_comb begin
      w_state_nxt = r_state;
      if (dac_data_sync) begin
         w_state_nxt = dac_enable ? c_ST_PREFILL : c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (dac_enable) w_state_nxt = c_ST_PREFILL;
            end
            c_ST_PREFILL: begin
               if (!dac_enable)               w_state_nxt = c_ST_IDLE;
               else if (r_level >= c_LVL_PRE) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
               if (!dac_enable)        w_state_nxt = c_ST_IDLE;
               else if (r_level == '0) w_state_nxt = c_ST_UNDERFLOW;
            end
            c_ST_UNDERFLOW: begin
               w_state_nxt = c_ST_PREFILL;
            end
            default: begin
               w_state_nxt = c_ST_IDLE;
            end
         endcase
      end
   end

   // FSM outputs: pop while running with data, flag an empty running cycle
   always_comb begin
      w_pop = 1'b0;
      w_uf  = 1'b0;
      if (!dac_data_sync && (r_state == c_ST_RUN)) begin
         w_pop = (r_level != '0);
         w_uf  = (r_level == '0) & dac_enable;
      end
   end

   // Occupancy after this cycle's push/pop, used for both level and ready
   always_comb begin
      w_level_nxt = r_level;
      if (dac_data_sync) begin
         w_level_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_level_nxt = r_level + c_LVL_ONE;
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - c_LVL_ONE;
      end
   end

   // Pointers, level and registered ready
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ready  <= 1'b0;
      end else begin
         r_level <= w_level_nxt;
         r_ready <= (w_level_nxt < c_LVL_FULL);
         if (dac_data_sync) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   // Output beat register, underflow pulse and saturating event counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dma_data      <= '0;
         r_dma_underflow <= 1'b0;
         r_underflow_cnt <= 16'd0;
      end else begin
         r_dma_data      <= w_pop ? w_rd_data : '0;
         r_dma_underflow <= w_uf;
         if (w_uf) begin
            r_underflow_cnt <= f_sat_inc16(r_underflow_cnt);
         end
      end
   end

endmodule
`default_nettype wire
